alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Pipeline stage directly upstream of alu. Decodes RV32I opcode/funct fields into alu_op_select,
//  alu_mux1_select and alu_mux2_select, selects opd1..opd4 from rs1/rs2/imm/pc, and registers the
//  bundle behind a valid/ready handshake with a 2-entry skid buffer. Outputs drive alu inputs directly.
// PARAMETERS
//  OPERAND_LENGTH  32  width of rs1/rs2/imm/pc and of opd1..opd4
// PORTS
//  clk              in   1    single clock, all state on rising edge
//  rst              in   1    asynchronous, active-high reset
//  flush            in   1    synchronous kill of all buffered entries
//  in_valid         in   1    upstream bundle valid
//  in_ready         out  1    stage can accept (registered)
//  opcode           in   7    RV32I opcode
//  funct3           in   3    RV32I funct3
//  funct7_5         in   1    instr bit 30
//  rs1_data         in   OL   register operand 1
//  rs2_data         in   OL   register operand 2
//  imm              in   OL   sign-extended immediate
//  pc               in   OL   instruction address
//  out_valid        out  1    bundle on opd*/sel* valid
//  out_ready        in   1    downstream accepts
//  opd1..opd4       out  OL   alu operands
//  alu_mux1_select  out  1    0: compare opd1/opd2, 1: compare opd3/opd4
//  alu_mux2_select  out  2    00 adder, 01 logic, 10 shifter, 11 compare
//  alu_op_select    out  4    operation code (table below)
//  illegal          out  1    decoded opcode unsupported
// BEHAVIOUR
//  Op codes: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLL, 0110 SRL, 0111 SRA,
//   1000 SLT, 1001 SLTU, 1010 BEQ, 1011 BNE, 1100 BLT, 1101 BGE, 1110 BLTU, 1111 BGEU.
//   Adder subtracts only for 0001; every other code adds.
//  Decode (opd3=rs1_data, opd4=rs2_data always):
//   OP 0110011: opd1=rs1, opd2=rs2, mux1=0; f3 000 ADD/SUB(f7_5), 001 SLL, 010 SLT, 011 SLTU,
//     100 XOR, 101 SRL/SRA(f7_5), 110 OR, 111 AND; mux2 from op class.
//   OP-IMM 0010011: as OP with opd2=imm; f3 000 always ADD (f7_5 ignored).
//   BRANCH 1100011: opd1=pc, opd2=imm, mux1=1, mux2=00, op from f3 (000 BEQ,001 BNE,100 BLT,
//     101 BGE,110 BLTU,111 BGEU); f3 010/011 -> illegal.
//   LUI 0110111: opd1=0, opd2=imm, ADD. AUIPC 0010111: opd1=pc, opd2=imm, ADD.
//   JAL 1101111 / JALR 1100111: opd1=pc, opd2=4, ADD.
//   Any other opcode: illegal=1, opd1..4=0, op ADD, mux1=0, mux2=00; entry still flows.
//  Handshake: transfer in on in_valid&in_ready; out on out_valid&out_ready. Entries in order.
//  Buffer: output reg (OUT) + skid reg (SKID). in_ready = !SKID.valid, registered.
//   accept & (!OUT.valid | out_ready & !SKID.valid) -> decoded bundle loads OUT.
//   accept & OUT.valid & !out_ready -> loads SKID.
//   OUT drains (out_ready) & SKID.valid -> SKID moves to OUT; simultaneous accept loads SKID.
//  Latency 1 cycle in_valid -> out_valid; full throughput 1/cycle with out_ready high.
//  Output data held stable while out_valid & !out_ready.
//  flush: next edge clears OUT.valid, SKID.valid; in_valid ignored that cycle; in_ready=1 after.
//  Reset (async assert): out_valid=0, in_ready=1, opd1..4=0, all selects 0, illegal=0.
//   Reset mid-transfer discards both entries; nothing emitted after release until new accept.
// TESTING
//  OP f3=000 f7_5=1 rs1=10 rs2=3 -> next cycle out_valid=1, op=0001, mux2=00, opd1=10, opd2=3.
//  BRANCH f3=100 pc=0x100 imm=0x20 rs1=-1 rs2=1 -> op=1100, mux1=1, opd1=0x100, opd2=0x20, opd3=-1.
//  out_ready=0, 3 back-to-back valids -> 2 accepted, in_ready=0 on 3rd; release -> A,B in order.
//  Both entries full, flush=1 -> next cycle out_valid=0, in_ready=1; no stale output.
//  opcode=0000000 -> illegal=1, opd1..4=0, op=0000; handshake completes normally.
//  rst pulsed mid-stall with OUT and SKID full -> out_valid=0, in_ready=1 immediately (async).

Source files
------------

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes RV32I opcode/funct fields into alu selects and operands,
// and registers the bundle behind a valid/ready handshake with a 2-entry skid buffer.
// Ports:
//   clk, rst (async, active-high), flush (sync kill of buffered entries)
//   in_valid/in_ready          upstream handshake (in_ready registered)
//   opcode, funct3, funct7_5   instruction fields
//   rs1_data, rs2_data, imm, pc  operand sources
//   out_valid/out_ready        downstream handshake
//   opd1..opd4, alu_mux1_select, alu_mux2_select, alu_op_select, illegal  registered alu bundle
module alu_issue_stage #(
    parameter int unsigned OPERAND_LENGTH = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [6:0]                opcode,
    input  logic [2:0]                funct3,
    input  logic                      funct7_5,
    input  logic [OPERAND_LENGTH-1:0] rs1_data,
    input  logic [OPERAND_LENGTH-1:0] rs2_data,
    input  logic [OPERAND_LENGTH-1:0] imm,
    input  logic [OPERAND_LENGTH-1:0] pc,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OPERAND_LENGTH-1:0] opd1,
    output logic [OPERAND_LENGTH-1:0] opd2,
    output logic [OPERAND_LENGTH-1:0] opd3,
    output logic [OPERAND_LENGTH-1:0] opd4,
    output logic                      alu_mux1_select,
    output logic [1:0]                alu_mux2_select,
    output logic [3:0]                alu_op_select,
    output logic                      illegal
);
    localparam int unsigned OL = OPERAND_LENGTH;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] OP_ADD  = 4'b0000, OP_SUB  = 4'b0001, OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011, OP_XOR  = 4'b0100, OP_SLL  = 4'b0101;
    localparam logic [3:0] OP_SRL  = 4'b0110, OP_SRA  = 4'b0111, OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001, OP_BEQ  = 4'b1010, OP_BNE  = 4'b1011;
    localparam logic [3:0] OP_BLT  = 4'b1100, OP_BGE  = 4'b1101, OP_BLTU = 4'b1110;
    localparam logic [3:0] OP_BGEU = 4'b1111;

    typedef struct packed {
        logic [OL-1:0] opd1;
        logic [OL-1:0] opd2;
        logic [OL-1:0] opd3;
        logic [OL-1:0] opd4;
        logic          mux1;
        logic [1:0]    mux2;
        logic [3:0]    op;
        logic          illegal;
    } bundle_t;

    bundle_t dec;
    bundle_t out_b, out_b_n, skid_b, skid_b_n;
    logic    out_v, out_v_n, skid_v, skid_v_n;
    logic    accept;

    // alu unit selected by a register/immediate arithmetic op
    function automatic logic [1:0] op_class(input logic [3:0] op);
        case (op)
            OP_AND, OP_OR, OP_XOR:   op_class = 2'b01;
            OP_SLL, OP_SRL, OP_SRA:  op_class = 2'b10;
            OP_SLT, OP_SLTU:         op_class = 2'b11;
            default:                 op_class = 2'b00;
        endcase
    endfunction

    // Instruction decode and operand selection
    always_comb begin
        dec      = '0;
        dec.opd3 = rs1_data;
        dec.opd4 = rs2_data;
        case (opcode)
            OPC_OP, OPC_OPIMM: begin
                dec.opd1 = rs1_data;
                dec.opd2 = (opcode == OPC_OP) ? rs2_data : imm;
                case (funct3)
                    3'b000:  dec.op = (opcode == OPC_OP && funct7_5) ? OP_SUB : OP_ADD;
                    3'b001:  dec.op = OP_SLL;
                    3'b010:  dec.op = OP_SLT;
                    3'b011:  dec.op = OP_SLTU;
                    3'b100:  dec.op = OP_XOR;
                    3'b101:  dec.op = funct7_5 ? OP_SRA : OP_SRL;
                    3'b110:  dec.op = OP_OR;
                    default: dec.op = OP_AND;
                endcase
                dec.mux2 = op_class(dec.op);
            end
            OPC_BRANCH: begin
                dec.opd1 = pc;
                dec.opd2 = imm;
                dec.mux1 = 1'b1;
                case (funct3)
                    3'b000:  dec.op = OP_BEQ;
                    3'b001:  dec.op = OP_BNE;
                    3'b100:  dec.op = OP_BLT;
                    3'b101:  dec.op = OP_BGE;
                    3'b110:  dec.op = OP_BLTU;
                    3'b111:  dec.op = OP_BGEU;
                    default: begin
                        dec         = '0;
                        dec.illegal = 1'b1;
                    end
                endcase
            end
            OPC_LUI: begin
                dec.opd2 = imm;
            end
            OPC_AUIPC: begin
                dec.opd1 = pc;
                dec.opd2 = imm;
            end
            OPC_JAL, OPC_JALR: begin
                dec.opd1 = pc;
                dec.opd2 = OL'(4);
            end
            default: begin
                dec         = '0;
                dec.illegal = 1'b1;
            end
        endcase
    end

    assign accept = in_valid & in_ready;

    // Output/skid buffer next state; in_ready is never high while SKID holds an entry
    always_comb begin
        out_v_n  = out_v;
        skid_v_n = skid_v;
        out_b_n  = out_b;
        skid_b_n = skid_b;
        if (flush) begin
            out_v_n  = 1'b0;
            skid_v_n = 1'b0;
        end else if (skid_v) begin
            if (out_ready) begin
                out_b_n  = skid_b;
                skid_v_n = 1'b0;
            end
        end else if (accept) begin
            if (!out_v || out_ready) begin
                out_b_n = dec;
                out_v_n = 1'b1;
            end else begin
                skid_b_n = dec;
                skid_v_n = 1'b1;
            end
        end else if (out_ready) begin
            out_v_n = 1'b0;
        end
    end

    // Buffer registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_v    <= 1'b0;
            skid_v   <= 1'b0;
            out_b    <= '0;
            skid_b   <= '0;
            in_ready <= 1'b1;
        end else begin
            out_v    <= out_v_n;
            skid_v   <= skid_v_n;
            out_b    <= out_b_n;
            skid_b   <= skid_b_n;
            in_ready <= !skid_v_n;
        end
    end

    assign out_valid       = out_v;
    assign opd1            = out_b.opd1;
    assign opd2            = out_b.opd2;
    assign opd3            = out_b.opd3;
    assign opd4            = out_b.opd4;
    assign alu_mux1_select = out_b.mux1;
    assign alu_mux2_select = out_b.mux2;
    assign alu_op_select   = out_b.op;
    assign illegal         = out_b.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage: decode table, skid buffering, flush, async reset.
module tb_alu_issue_stage;
    logic        clk = 1'b0;
    logic        rst, flush, in_valid, in_ready, funct7_5, out_valid, out_ready;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] rs1_data, rs2_data, imm, pc, opd1, opd2, opd3, opd4;
    logic        alu_mux1_select, illegal;
    logic [1:0]  alu_mux2_select;
    logic [3:0]  alu_op_select;

    int vectors = 0;
    int miscompares = 0;

    alu_issue_stage #(.OPERAND_LENGTH(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .imm(imm), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .opd1(opd1), .opd2(opd2), .opd3(opd3), .opd4(opd4),
        .alu_mux1_select(alu_mux1_select), .alu_mux2_select(alu_mux2_select),
        .alu_op_select(alu_op_select), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        f7;
        logic [3:0]  op;
        logic        m1;
        logic [1:0]  m2;
        logic [31:0] e1;
        logic [31:0] e2;
        logic [31:0] e3;
        logic [31:0] e4;
        logic        ill;
    } dvec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        opcode = o; funct3 = f3; funct7_5 = f7;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_instr(7'b0110011, 3'b000, 1'b0);
        rs1_data = '0; rs2_data = '0; imm = '0; pc = '0;
        step(); step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %0b exp 0", out_valid); end
        vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready got %0b exp 1", in_ready); end
        vectors++; if ({opd1, opd2, opd3, opd4} !== 128'd0) begin miscompares++; $display("FAIL reset_opds got %h %h %h %h exp 0", opd1, opd2, opd3, opd4); end
        vectors++; if ({alu_mux1_select, alu_mux2_select, alu_op_select, illegal} !== 8'd0) begin miscompares++; $display("FAIL reset_selects got %b exp 0", {alu_mux1_select, alu_mux2_select, alu_op_select, illegal}); end
        rst = 1'b0;
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL post_reset_idle got %0b exp 0", out_valid); end
    endtask

    task automatic test_sub();
        set_instr(7'b0110011, 3'b000, 1'b1);
        rs1_data = 32'd10; rs2_data = 32'd3; in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL sub_valid got %0b exp 1", out_valid); end
        vectors++; if (alu_op_select !== 4'b0001) begin miscompares++; $display("FAIL sub_op got %b exp 0001", alu_op_select); end
        vectors++; if (alu_mux2_select !== 2'b00) begin miscompares++; $display("FAIL sub_mux2 got %b exp 00", alu_mux2_select); end
        vectors++; if (opd1 !== 32'd10 || opd2 !== 32'd3) begin miscompares++; $display("FAIL sub_opds got %0d %0d exp 10 3", opd1, opd2); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL sub_drain got %0b exp 0", out_valid); end
    endtask

    task automatic test_branch();
        set_instr(7'b1100011, 3'b100, 1'b0);
        pc = 32'h100; imm = 32'h20; rs1_data = 32'hFFFF_FFFF; rs2_data = 32'd1;
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        vectors++; if (alu_op_select !== 4'b1100 || alu_mux1_select !== 1'b1) begin miscompares++; $display("FAIL blt_sel got op=%b m1=%b exp 1100 1", alu_op_select, alu_mux1_select); end
        vectors++; if (opd1 !== 32'h100 || opd2 !== 32'h20) begin miscompares++; $display("FAIL blt_opd12 got %h %h exp 100 20", opd1, opd2); end
        vectors++; if (opd3 !== 32'hFFFF_FFFF || opd4 !== 32'd1) begin miscompares++; $display("FAIL blt_opd34 got %h %h exp ffffffff 1", opd3, opd4); end
        step();
    endtask

    task automatic test_decode();
        dvec_t tv [17];
        tv[0]  = '{7'b0110011, 3'b000, 1'b0, 4'b0000, 1'b0, 2'b00, 32'h11, 32'h22, 32'h11, 32'h22, 1'b0};
        tv[1]  = '{7'b0110011, 3'b101, 1'b1, 4'b0111, 1'b0, 2'b10, 32'h11, 32'h22, 32'h11, 32'h22, 1'b0};
        tv[2]  = '{7'b0110011, 3'b101, 1'b0, 4'b0110, 1'b0, 2'b10, 32'h11, 32'h22, 32'h11, 32'h22, 1'b0};
        tv[3]  = '{7'b0110011, 3'b010, 1'b0, 4'b1000, 1'b0, 2'b11, 32'h11, 32'h22, 32'h11, 32'h22, 1'b0};
        tv[4]  = '{7'b0110011, 3'b011, 1'b0, 4'b1001, 1'b0, 2'b11, 32'h11, 32'h22, 32'h11, 32'h22, 1'b0};
        tv[5]  = '{7'b0110011, 3'b100, 1'b0, 4'b0100, 1'b0, 2'b01, 32'h11, 32'h22, 32'h11, 32'h22, 1'b0};
        tv[6]  = '{7'b0110011, 3'b111, 1'b0, 4'b0010, 1'b0, 2'b01, 32'h11, 32'h22, 32'h11, 32'h22, 1'b0};
        tv[7]  = '{7'b0110011, 3'b001, 1'b0, 4'b0101, 1'b0, 2'b10, 32'h11, 32'h22, 32'h11, 32'h22, 1'b0};
        tv[8]  = '{7'b0010011, 3'b000, 1'b1, 4'b0000, 1'b0, 2'b00, 32'h11, 32'h33, 32'h11, 32'h22, 1'b0};
        tv[9]  = '{7'b0010011, 3'b110, 1'b0, 4'b0011, 1'b0, 2'b01, 32'h11, 32'h33, 32'h11, 32'h22, 1'b0};
        tv[10] = '{7'b0010011, 3'b101, 1'b1, 4'b0111, 1'b0, 2'b10, 32'h11, 32'h33, 32'h11, 32'h22, 1'b0};
        tv[11] = '{7'b1100011, 3'b111, 1'b0, 4'b1111, 1'b1, 2'b00, 32'h44, 32'h33, 32'h11, 32'h22, 1'b0};
        tv[12] = '{7'b1100011, 3'b001, 1'b0, 4'b1011, 1'b1, 2'b00, 32'h44, 32'h33, 32'h11, 32'h22, 1'b0};
        tv[13] = '{7'b0110111, 3'b000, 1'b0, 4'b0000, 1'b0, 2'b00, 32'h00, 32'h33, 32'h11, 32'h22, 1'b0};
        tv[14] = '{7'b0010111, 3'b000, 1'b0, 4'b0000, 1'b0, 2'b00, 32'h44, 32'h33, 32'h11, 32'h22, 1'b0};
        tv[15] = '{7'b1101111, 3'b000, 1'b0, 4'b0000, 1'b0, 2'b00, 32'h44, 32'h04, 32'h11, 32'h22, 1'b0};
        tv[16] = '{7'b1100111, 3'b000, 1'b0, 4'b0000, 1'b0, 2'b00, 32'h44, 32'h04, 32'h11, 32'h22, 1'b0};
        rs1_data = 32'h11; rs2_data = 32'h22; imm = 32'h33; pc = 32'h44;
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            set_instr(tv[i].opc, tv[i].f3, tv[i].f7);
            in_valid = 1'b1;
            step();
            vectors++;
            if (out_valid !== 1'b1 || alu_op_select !== tv[i].op || alu_mux1_select !== tv[i].m1 ||
                alu_mux2_select !== tv[i].m2 || illegal !== tv[i].ill || opd1 !== tv[i].e1 ||
                opd2 !== tv[i].e2 || opd3 !== tv[i].e3 || opd4 !== tv[i].e4) begin
                miscompares++;
                $display("FAIL decode[%0d] got v=%b op=%b m1=%b m2=%b ill=%b %h %h %h %h exp v=1 op=%b m1=%b m2=%b ill=%b %h %h %h %h",
                         i, out_valid, alu_op_select, alu_mux1_select, alu_mux2_select, illegal, opd1, opd2, opd3, opd4,
                         tv[i].op, tv[i].m1, tv[i].m2, tv[i].ill, tv[i].e1, tv[i].e2, tv[i].e3, tv[i].e4);
            end
        end
        in_valid = 1'b0;
        step();
    endtask

    task automatic test_skid();
        set_instr(7'b0110011, 3'b000, 1'b0);
        out_ready = 1'b0; in_valid = 1'b1;
        rs1_data = 32'hA; step();
        vectors++; if (in_ready !== 1'b1 || opd1 !== 32'hA) begin miscompares++; $display("FAIL skid_a got rdy=%b opd1=%h exp 1 a", in_ready, opd1); end
        rs1_data = 32'hB; step();
        vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL skid_full_rdy got %b exp 0", in_ready); end
        rs1_data = 32'hC; step(); step();
        vectors++; if (out_valid !== 1'b1 || opd1 !== 32'hA || in_ready !== 1'b0) begin miscompares++; $display("FAIL skid_hold got v=%b opd1=%h rdy=%b exp 1 a 0", out_valid, opd1, in_ready); end
        in_valid = 1'b0; out_ready = 1'b1; step();
        vectors++; if (out_valid !== 1'b1 || opd1 !== 32'hB || in_ready !== 1'b1) begin miscompares++; $display("FAIL skid_b got v=%b opd1=%h rdy=%b exp 1 b 1", out_valid, opd1, in_ready); end
        step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL skid_empty got %b exp 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        set_instr(7'b0110011, 3'b000, 1'b0);
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            rs1_data = 32'(100 + i);
            step();
            vectors++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || opd1 !== 32'(100 + i)) begin
                miscompares++; $display("FAIL b2b[%0d] got v=%b rdy=%b opd1=%0d exp 1 1 %0d", i, out_valid, in_ready, opd1, 100 + i);
            end
        end
        in_valid = 1'b0; step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_end got %b exp 0", out_valid); end
    endtask

    task automatic test_flush();
        set_instr(7'b0110011, 3'b000, 1'b0);
        out_ready = 1'b0; in_valid = 1'b1;
        rs1_data = 32'h1; step();
        rs1_data = 32'h2; step();
        flush = 1'b1; rs1_data = 32'h3; step();
        flush = 1'b0;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL flush got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
        in_valid = 1'b0; out_ready = 1'b1; step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_stale got %b exp 0", out_valid); end
    endtask

    task automatic test_illegal();
        set_instr(7'b0000000, 3'b000, 1'b0);
        rs1_data = 32'h55; rs2_data = 32'h66; imm = 32'h77; pc = 32'h88;
        out_ready = 1'b0; in_valid = 1'b1; step();
        in_valid = 1'b0;
        vectors++; if (out_valid !== 1'b1 || illegal !== 1'b1 || alu_op_select !== 4'b0000) begin miscompares++; $display("FAIL illegal_flags got v=%b ill=%b op=%b exp 1 1 0000", out_valid, illegal, alu_op_select); end
        vectors++; if ({opd1, opd2, opd3, opd4} !== 128'd0) begin miscompares++; $display("FAIL illegal_opds got %h %h %h %h exp 0", opd1, opd2, opd3, opd4); end
        out_ready = 1'b1; step();
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin miscompares++; $display("FAIL illegal_drain got v=%b rdy=%b exp 0 1", out_valid, in_ready); end
    endtask

    task automatic test_async_reset();
        set_instr(7'b0110011, 3'b000, 1'b0);
        out_ready = 1'b0; in_valid = 1'b1;
        rs1_data = 32'h9; step();
        rs1_data = 32'hA; step();
        in_valid = 1'b0;
        #3 rst = 1'b1;
        #1;
        vectors++; if (out_valid !== 1'b0 || in_ready !== 1'b1 || opd1 !== 32'd0) begin miscompares++; $display("FAIL async_rst got v=%b rdy=%b opd1=%h exp 0 1 0", out_valid, in_ready, opd1); end
        #1 rst = 1'b0;
        out_ready = 1'b1; step(); step();
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_no_stale got %b exp 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_sub();
        test_branch();
        test_decode();
        test_skid();
        test_back_to_back();
        test_flush();
        test_illegal();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
